// File: rtl/uart_tx_frame.sv
// UART frame transmitter: start bit, LSB-first data, optional parity, stop bit.
// Each bit is held for prescale+1 clocks. Frame fields are captured when a request is accepted.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_WIDTH-1:0]     p_data,
  input  logic                      data_valid,
  input  logic                      par_en,
  input  logic                      par_typ,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                    state_q, state_n;
  logic [PRESCALE_WIDTH-1:0] tick_q, tick_n;
  logic [IDX_W-1:0]          idx_q, idx_n;
  logic [DATA_WIDTH-1:0]     data_q, data_n;
  logic                      par_en_q, par_en_n;
  logic                      par_typ_q, par_typ_n;
  logic [PRESCALE_WIDTH-1:0] prescale_q, prescale_n;
  logic                      tx_q, tx_n;
  logic                      busy_q, busy_n;

  logic                      bit_done;
  logic [IDX_W-1:0]          idx_inc;
  logic                      par_bit;

  assign bit_done = (tick_q == prescale_q);
  assign idx_inc  = idx_q + 1'b1;
  assign par_bit  = (^data_q) ^ par_typ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      tick_q     <= '0;
      idx_q      <= '0;
      data_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      prescale_q <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_n;
      tick_q     <= tick_n;
      idx_q      <= idx_n;
      data_q     <= data_n;
      par_en_q   <= par_en_n;
      par_typ_q  <= par_typ_n;
      prescale_q <= prescale_n;
      tx_q       <= tx_n;
      busy_q     <= busy_n;
    end
  end

  // tx_n is the value the line takes for the whole next bit, so the output stays registered.
  always_comb begin
    state_n    = state_q;
    tick_n     = tick_q;
    idx_n      = idx_q;
    data_n     = data_q;
    par_en_n   = par_en_q;
    par_typ_n  = par_typ_q;
    prescale_n = prescale_q;
    tx_n       = tx_q;
    busy_n     = busy_q;

    if (state_q != IDLE) begin
      tick_n = bit_done ? '0 : tick_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        tx_n   = 1'b1;
        busy_n = 1'b0;
        if (data_valid) begin
          state_n    = START;
          tick_n     = '0;
          data_n     = p_data;
          par_en_n   = par_en;
          par_typ_n  = par_typ;
          prescale_n = prescale;
          tx_n       = 1'b0;
          busy_n     = 1'b1;
        end
      end
      START: begin
        if (bit_done) begin
          state_n = DATA;
          idx_n   = '0;
          tx_n    = data_q[0];
        end
      end
      DATA: begin
        if (bit_done) begin
          if (idx_q == IDX_LAST) begin
            state_n = par_en_q ? PARITY : STOP;
            tx_n    = par_en_q ? par_bit : 1'b1;
          end else begin
            idx_n = idx_inc;
            tx_n  = data_q[idx_inc];
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_n = STOP;
          tx_n    = 1'b1;
        end
      end
      STOP: begin
        if (bit_done) begin
          state_n = IDLE;
          tx_n    = 1'b1;
          busy_n  = 1'b0;
        end
      end
      default: begin
        state_n = IDLE;
        tick_n  = '0;
        tx_n    = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  assign tx_out = tx_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: directed and randomized frames compared clock-by-clock
// against an expected bit list built from the frame format.
module tb_uart_tx_frame;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] p_data;
  logic       data_valid;
  logic       par_en;
  logic       par_typ;
  logic [4:0] prescale;
  logic       tx_out;
  logic       busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(
    .DATA_WIDTH    (8),
    .PRESCALE_WIDTH(5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .p_data    (p_data),
    .data_valid(data_valid),
    .par_en    (par_en),
    .par_typ   (par_typ),
    .prescale  (prescale),
    .tx_out    (tx_out),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Called at a point where the DUT will accept on the next edge. Checks every clock of
  // the frame, then the busy-fall cycle. keep_valid leaves the request asserted;
  // mid_pulse injects a one-clock 8'hFF request inside the frame.
  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic [4:0] ps, input bit keep_valid, input bit mid_pulse,
                           input string name);
    logic bits[$];
    int   per;
    int   total;
    bits.delete();
    bits.push_back(1'b0);
    for (int b = 0; b < 8; b++) bits.push_back(d[b]);
    if (pen) bits.push_back(logic'(($countones(d) % 2) != 0) ^ ptyp);
    bits.push_back(1'b1);
    per   = int'(ps) + 1;
    total = bits.size() * per;

    p_data     = d;
    par_en     = pen;
    par_typ    = ptyp;
    prescale   = ps;
    data_valid = 1'b1;
    @(posedge clk);
    for (int i = 0; i < total; i++) begin
      #1;
      chk($sformatf("%s tx clk%0d", name, i), tx_out, bits[i / per]);
      chk($sformatf("%s busy clk%0d", name, i), busy, 1'b1);
      if (i == 0 && !keep_valid) begin
        data_valid = 1'b0;
        p_data     = 8'($urandom);
        par_en     = 1'($urandom);
        par_typ    = 1'($urandom);
        prescale   = 5'($urandom);
      end
      if (mid_pulse && i == 3 * per) begin
        data_valid = 1'b1;
        p_data     = 8'hFF;
      end
      if (mid_pulse && i == 3 * per + 1) data_valid = 1'b0;
      @(posedge clk);
    end
    #1;
    chk($sformatf("%s end busy", name), busy, 1'b0);
    chk($sformatf("%s end tx", name), tx_out, 1'b1);
  endtask

  task automatic check_idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s idle tx", name), tx_out, 1'b1);
      chk($sformatf("%s idle busy", name), busy, 1'b0);
    end
  endtask

  initial begin
    logic [4:0] ps;
    rst        = 1'b1;
    data_valid = 1'b0;
    p_data     = '0;
    par_en     = 1'b0;
    par_typ    = 1'b0;
    prescale   = 5'd7;

    // Held in reset while requests toggle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      data_valid = 1'($urandom);
      p_data     = 8'($urandom);
      #1;
      chk("reset tx", tx_out, 1'b1);
      chk("reset busy", busy, 1'b0);
    end
    @(negedge clk);
    rst        = 1'b0;
    data_valid = 1'b0;
    check_idle(3, "post-reset");

    run_frame(8'hA5, 1'b0, 1'b0, 5'd7,  1'b0, 1'b0, "a5_ps7");
    run_frame(8'h03, 1'b1, 1'b0, 5'd15, 1'b0, 1'b0, "03_even");
    run_frame(8'h03, 1'b1, 1'b1, 5'd15, 1'b0, 1'b0, "03_odd");

    run_frame(8'h5C, 1'b1, 1'b1, 5'd7, 1'b0, 1'b1, "midpulse");
    check_idle(4, "midpulse");

    // Held request: the second frame starts after exactly one idle-high clock.
    run_frame(8'h96, 1'b0, 1'b0, 5'd31, 1'b1, 1'b0, "held1");
    run_frame(8'h69, 1'b1, 1'b0, 5'd31, 1'b0, 1'b0, "held2");
    check_idle(2, "held");

    run_frame(8'hC3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, "ps0");

    for (int f = 0; f < 24; f++) begin
      case ($urandom_range(0, 4))
        0:       ps = 5'd0;
        1:       ps = 5'd7;
        2:       ps = 5'd15;
        3:       ps = 5'd31;
        default: ps = 5'($urandom_range(0, 31));
      endcase
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), ps, 1'b0, 1'b0,
                $sformatf("rnd%0d", f));
      if ($urandom_range(0, 1) == 1) check_idle(1, "rnd gap");
    end

    // Asynchronous reset in the middle of the data bits.
    p_data     = 8'h00;
    par_en     = 1'b1;
    par_typ    = 1'b0;
    prescale   = 5'd7;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("pre-rst busy", busy, 1'b1);
    chk("pre-rst tx", tx_out, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-rst tx", tx_out, 1'b1);
    chk("mid-rst busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    check_idle(3, "after mid-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
